// File: rtl/mem_pkg.sv
// mem_pkg: access-size and FSM state encodings shared by the data-memory responder.
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_BUSY
    } state_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request and single-cycle response bus.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store merge, load extract/extend and alignment check.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_ldata,
    output logic        o_mis
);
    logic [31:0] w_rep;
    logic [31:0] w_sh;

    // Replicating store data across lanes lets the enable mask pick the right copy.
    assign w_rep = i_size == SZ_BYTE ? {4{i_wdata[7:0]}} :
                   i_size == SZ_HALF ? {2{i_wdata[15:0]}} : i_wdata;
    assign o_be  = i_size == SZ_BYTE ? 4'b0001 << i_addr :
                   i_size == SZ_HALF ? 4'b0011 << {i_addr[1], 1'b0} :
                   i_size == SZ_WORD ? 4'hf : 4'h0;
    assign o_mis = i_size == 2'b11 || (i_size == SZ_HALF && i_addr[0]) ||
                   (i_size == SZ_WORD && i_addr != 2'b00);
    assign w_sh  = i_rword >> {i_addr, 3'b000};
    assign o_ldata = i_size == SZ_BYTE ? {{24{~i_uns & w_sh[7]}}, w_sh[7:0]} :
                     i_size == SZ_HALF ? {{16{~i_uns & w_sh[15]}}, w_sh[15:0]} : i_rword;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign o_wword[8*i+:8] = o_be[i] ? w_rep[8*i+:8] : i_rword[8*i+:8];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data memory answering one load/store at a time.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input logic rclk,
    input logic rst,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_we, r_uns;
    logic [31:0] r_addr, r_wdata;
    logic [1:0]  r_size;
    logic        r_rsp_valid, r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept, w_fire, w_oob, w_mis, w_err;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_rword, w_wword, w_ldata;

    assign w_accept = r_state == ST_IDLE && bus.req_valid;
    assign w_fire   = r_state == ST_BUSY && r_cnt == 4'd0;
    assign w_idx    = r_addr[AW+1:2];
    // Addresses beyond the array fault instead of aliasing onto low words.
    assign w_oob    = |(r_addr[31:2] >> AW);
    assign w_err    = w_mis || w_oob;
    assign w_rword  = r_mem[w_idx];

    mem_lane_align u_align (
        .i_addr  (r_addr[1:0]),
        .i_size  (r_size),
        .i_uns   (r_uns),
        .i_wdata (r_wdata),
        .i_rword (w_rword),
        .o_be    (w_be),
        .o_wword (w_wword),
        .o_ldata (w_ldata),
        .o_mis   (w_mis)
    );

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) r_state <= ST_INIT;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_INIT) w_next = ST_IDLE;
        else if (w_accept)      w_next = ST_BUSY;
        else if (w_fire)        w_next = ST_IDLE;
    end

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_cnt   <= 4'(LATENCY - 1);
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_size  <= bus.req_size;
                r_uns   <= bus.req_unsigned;
            end else if (r_state == ST_BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_rsp_valid <= w_fire;
            r_rsp_err   <= w_fire && w_err;
            r_rsp_rdata <= (w_fire && !w_err && !r_we) ? w_ldata : 32'd0;
        end
    end

    // Storage is deliberately not reset; a reset mid-access leaves state INIT so no write fires.
    always_ff @(posedge rclk) begin
        if (w_fire && r_we && !w_err && |w_be) r_mem[w_idx] <= w_wword;
    end

    assign bus.req_ready = r_state == ST_IDLE;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: byte-addressed reference model checked every cycle plus directed literal checks.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic rclk = 1'b0;
    logic rst  = 1'b0;
    always #5 rclk = ~rclk;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .rclk (rclk),
        .rst  (rst),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  m_mem [4*DEPTH];
    int          cyc = 0;
    int          acc = 0;
    bit          pending = 0;
    bit          m_ready = 0;
    logic        p_we, p_u;
    logic [31:0] p_addr, p_wd;
    logic [1:0]  p_sz;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: memory as bytes, response computed from the access rules directly.
    task automatic model_resp(output logic [31:0] rd, output logic e);
        int nb;
        rd = 32'd0;
        e  = p_sz == 2'b11 || (p_sz == SZ_HALF && p_addr[0]) ||
             (p_sz == SZ_WORD && p_addr[1:0] != 2'b00) || p_addr >= 32'(4 * DEPTH);
        nb = p_sz == SZ_BYTE ? 1 : p_sz == SZ_HALF ? 2 : 4;
        if (!e) begin
            if (p_we) begin
                for (int i = 0; i < nb; i++) m_mem[p_addr + 32'(i)] = p_wd[8*i+:8];
            end else begin
                for (int i = 0; i < nb; i++) rd[8*i+:8] = m_mem[p_addr + 32'(i)];
                if (!p_u && nb < 4 && rd[8*nb-1])
                    for (int i = 8 * nb; i < 32; i++) rd[i] = 1'b1;
            end
        end
    endtask

    always @(posedge rclk) begin
        if (!rst) begin
            cyc     = 0;
            pending = 0;
        end else begin
            cyc++;
            if (m_ready && bus.req_valid) begin
                pending = 1;
                acc     = cyc;
                p_we    = bus.req_we;
                p_addr  = bus.req_addr;
                p_wd    = bus.req_wdata;
                p_sz    = bus.req_size;
                p_u     = bus.req_unsigned;
            end
        end
    end

    always @(negedge rclk) begin
        logic [31:0] erd;
        logic        ee, ev;
        erd = 32'd0;
        ee  = 1'b0;
        ev  = 1'b0;
        if (!rst) begin
            pending = 0;
            m_ready = 0;
        end else begin
            ev = pending && cyc == acc + LAT;
            if (ev) model_resp(erd, ee);
            if (pending && cyc >= acc + LAT) pending = 0;
            m_ready = cyc >= 1 && !pending;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(m_ready));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
        chk("rsp_err",   32'(bus.rsp_err),   32'(ee));
        chk("rsp_rdata", bus.rsp_rdata, erd);
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge rclk); #1;
        while (!bus.req_ready && n < 20) begin
            @(negedge rclk); #1;
            n++;
        end
        chk("ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic xact(input string nm, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic u, input logic [31:0] er, input logic ee);
        int n = 0;
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        @(negedge rclk); #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        while (!bus.rsp_valid && n < LAT + 4) begin
            @(negedge rclk); #1;
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(LAT));
        chk({nm, "_rdata"}, bus.rsp_rdata, er);
        chk({nm, "_err"}, 32'(bus.rsp_err), 32'(ee));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_cnt, acc_cnt;
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        repeat (2) @(negedge rclk);
        #1;
        chk("reset_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        chk("init_ready", 32'(bus.req_ready), 32'd0);
        @(negedge rclk); #1;
        chk("idle_ready", 32'(bus.req_ready), 32'd1);

        xact("sw_dead",   1, 32'h10,  32'hDEADBEEF, SZ_WORD, 0, 32'h0,        0);
        xact("lw_dead",   0, 32'h10,  32'h0,        SZ_WORD, 0, 32'hDEADBEEF, 0);
        xact("sw_1234",   1, 32'h10,  32'h12345678, SZ_WORD, 0, 32'h0,        0);
        xact("sb_80",     1, 32'h13,  32'hFFFFFF80, SZ_BYTE, 0, 32'h0,        0);
        xact("lw_after_sb", 0, 32'h10, 32'h0,       SZ_WORD, 1, 32'h80345678, 0);
        xact("lb_13",     0, 32'h13,  32'h0,        SZ_BYTE, 0, 32'hFFFFFF80, 0);
        xact("lbu_13",    0, 32'h13,  32'h0,        SZ_BYTE, 1, 32'h00000080, 0);
        xact("sh_beef",   1, 32'h10,  32'h1234BEEF, SZ_HALF, 0, 32'h0,        0);
        xact("lw_after_sh", 0, 32'h10, 32'h0,       SZ_WORD, 0, 32'h8034BEEF, 0);
        xact("lh_10",     0, 32'h10,  32'h0,        SZ_HALF, 0, 32'hFFFFBEEF, 0);
        xact("lhu_12",    0, 32'h12,  32'h0,        SZ_HALF, 1, 32'h00008034, 0);
        xact("lw_mis",    0, 32'h11,  32'h0,        SZ_WORD, 0, 32'h0,        1);
        xact("sh_mis",    1, 32'h13,  32'h5555,     SZ_HALF, 0, 32'h0,        1);
        xact("lw_unchg",  0, 32'h10,  32'h0,        SZ_WORD, 0, 32'h8034BEEF, 0);
        xact("lw_oob",    0, 32'h400, 32'h0,        SZ_WORD, 0, 32'h0,        1);
        xact("size_ill",  0, 32'h10,  32'h0,        2'b11,   0, 32'h0,        1);
        xact("sw_last",   1, 32'h3FC, 32'hA5A5A5A5, SZ_WORD, 0, 32'h0,        0);
        xact("lw_last",   0, 32'h3FC, 32'h0,        SZ_WORD, 0, 32'hA5A5A5A5, 0);
        xact("sb_oob",    1, 32'h401, 32'h77,       SZ_BYTE, 0, 32'h0,        1);

        // Continuous valid: one accept every LAT+1 cycles.
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_size  = SZ_WORD;
        rsp_cnt = 0;
        acc_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            acc_cnt += int'(bus.req_ready && bus.req_valid);
            @(negedge rclk); #1;
            rsp_cnt += int'(bus.rsp_valid);
        end
        bus.req_valid = 1'b0;
        chk("hold_accepts", 32'(acc_cnt), 32'd3);
        chk("hold_rsp_count", 32'(rsp_cnt), 32'd3);

        // Reset one cycle after accepting a store: store and response must vanish.
        xact("sw_zero", 1, 32'h20, 32'h0, SZ_WORD, 0, 32'h0, 0);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hCAFEF00D;
        bus.req_size  = SZ_WORD;
        @(negedge rclk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        rsp_cnt = int'(bus.rsp_valid);
        @(negedge rclk); #1;
        rst = 1'b1;
        repeat (4) begin
            @(negedge rclk); #1;
            rsp_cnt += int'(bus.rsp_valid);
        end
        chk("midop_no_rsp", 32'(rsp_cnt), 32'd0);
        xact("lw_after_rst", 0, 32'h20, 32'h0, SZ_WORD, 0, 32'h0, 0);

        repeat (3) @(negedge rclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the memory side of the Datapath load/store interface.
- Accepts one load/store request at a time through a valid/ready handshake.
- Performs the access after a fixed latency and returns a single-cycle response carrying sign- or zero-extended load data or an error flag.
- Replaces the ideal combinational data memory so the Datapath can be brought up against realistic memory timing.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two.
- LATENCY, 2, cycles from the accepting edge to the response edge; legal range 1..15.

Ports:
- rclk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores and for errors.
- rsp_err  out  1  request faulted; qualified by rsp_valid.

Behaviour:
- Reset (rst low, asynchronous): state=INIT, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Memory array contents are not cleared by reset.
- States:
  - INIT: unconditionally goes to IDLE on the next edge.
  - IDLE: req_ready=1.
  - BUSY: req_ready=0.
- req_ready is decoded from state only (state==IDLE). It never depends combinationally on req_valid.
- Accept: at a rising edge with state==IDLE and req_valid=1:
  - latch we, addr, wdata, size, unsigned;
  - counter <= LATENCY-1;
  - state <= BUSY.
- BUSY with counter!=0: counter decrements each edge.
- BUSY with counter==0, at the next edge:
  - perform the access;
  - register rsp_valid=1 plus rdata and err;
  - state <= IDLE.
- Response timing: a request accepted at edge k gives rsp_valid high for exactly one cycle after edge k+LATENCY.
- req_ready returns to 1 in that same cycle, so a new request can be accepted at edge k+LATENCY+1. Back-to-back throughput is one request per LATENCY+1 cycles.
- rsp_valid, rsp_rdata and rsp_err hold 0 in every cycle other than a response cycle. There is no response backpressure and at most one request is outstanding.
- Error conditions, checked at access time:
  - size==11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - word index addr[31:2] >= DEPTH_WORDS.
- On error: no write, rsp_rdata=0, rsp_err=1.
- Word index is addr[31:2]. There is no wrap-around; out-of-range addresses are errors, never aliased.
- Store: only the addressed byte lanes change.
  - byte: lane addr[1:0] <= wdata[7:0];
  - half: lanes {addr[1],0}+1..{addr[1],0} <= wdata[15:0].
  - Other lanes are preserved.
  - Response is rsp_rdata=0, rsp_err=0.
- Load: extract the addressed lane(s) and shift to bit 0, then extend.
  - byte: bit 7 replicated into [31:8] when req_unsigned=0, else zeros.
  - half: bit 15 replicated into [31:16] when req_unsigned=0, else zeros.
  - word: unchanged; req_unsigned is ignored.
- Input changes while BUSY are ignored, because request fields are latched at accept.
- Reset mid-operation: any pending request is dropped. A write not yet performed never happens, no response is issued, and the block restarts from INIT.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encodings ST_INIT, ST_IDLE, ST_BUSY.
- Sub-module mem_lane_align (combinational), used by the top-level FSM and storage array:
  - inputs: addr[1:0], size, unsigned, wdata, stored word;
  - outputs: byte-enable mask, merged write word, extended load value, misalignment flag.

Test Plan:
- Reset/INIT: hold rst=0 for 2 cycles then release -> req_ready=0 through reset and first edge, 1 after second edge; rsp_valid never asserted.
- Word store/load, LATENCY=2: store addr 0x10 data 0xDEADBEEF accepted at edge k -> rsp_valid only after edge k+2, err=0, rdata=0; load 0x10 -> rdata 0xDEADBEEF.
- Byte/half lanes and extension: after word 0x10=0x12345678, store byte 0x80 to 0x13 -> word reads 0x80345678. Then:
  - lb 0x13 -> 0xFFFFFF80;
  - lbu 0x13 -> 0x00000080;
  - sh 0xBEEF to 0x10 -> word 0x8034BEEF;
  - lh 0x10 -> 0xFFFFBEEF.
- Errors: lw 0x11 -> err=1, rdata=0; sh to 0x13 -> err=1 and word unchanged; lw at 4*DEPTH_WORDS (0x400) -> err=1; size=11 -> err=1.
- Handshake: req_valid held high continuously -> exactly one accept per 3 cycles (LATENCY=2); req_addr changed while BUSY does not alter the response.
- Reset mid-op: sw 0x20=0xCAFEF00D accepted, rst pulsed low 1 cycle later -> no rsp_valid; subsequent lw 0x20 returns the prior value (0x00000000 after preload of zero).
